// File: rtl/mskaes_host_frontend_pkg.sv
// Shared types and constants for the masked AES-128 host frontend.
// Holds the FSM state encoding and the FIPS-197 C.1 reference vector.
package mskaes_host_frontend_pkg;

  localparam int BLK_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  localparam logic [BLK_W-1:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [BLK_W-1:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [BLK_W-1:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

endpackage

// File: rtl/mskaes_host_frontend_if.sv
// Host-side plaintext/key input stream and ciphertext output stream.
// master = system bus adapter, slave = frontend.
interface mskaes_host_frontend_if
  import mskaes_host_frontend_pkg::*;
#(
   parameter int d = 2
);
   logic                         in_valid;
   logic                         in_ready;
   logic [BLK_W-1:0]             in_plaintext;
   logic [BLK_W-1:0]             in_key;
   logic [2*BLK_W*(d-1)-1:0]     rnd_mask;
   logic                         out_valid;
   logic                         out_ready;
   logic [BLK_W-1:0]             out_ciphertext;

   modport master (
      output in_valid, in_plaintext, in_key, rnd_mask, out_ready,
      input  in_ready, out_valid, out_ciphertext
   );

   modport slave (
      input  in_valid, in_plaintext, in_key, rnd_mask, out_ready,
      output in_ready, out_valid, out_ciphertext
   );
endinterface

// File: rtl/msk_share_split.sv
// Combinational Boolean masking: x -> d shares, bit j share i at sh[d*j+i].
// Shares 1..d-1 are taken from rnd; share 0 absorbs x.
module msk_share_split #(
   parameter int d     = 2,
   parameter int count = 128
) (
   input  logic [count-1:0]       x,
   input  logic [count*(d-1)-1:0] rnd,
   output logic [count*d-1:0]     sh
);

   for (genvar j = 0; j < count; j++) begin : g_bit
      logic [d-2:0] r;
      for (genvar i = 1; i < d; i++) begin : g_share
         assign r[i-1]        = rnd[(i-1)*count + j];
         assign sh[d*j + i]   = r[i-1];
      end
      assign sh[d*j] = x[j] ^ (^r);
   end

endmodule

// File: rtl/mskaes_host_frontend.sv
// Initiator-side frontend for the masked AES-128 core: masks inputs, issues them,
// recombines the shared ciphertext. Optional WAIT watchdog via MSKAES_WDOG_EN.
module mskaes_host_frontend
  import mskaes_host_frontend_pkg::*;
#(
   parameter int d = 2
`ifdef MSKAES_WDOG_EN
   , parameter int TIMEOUT = 1023
`endif
) (
   input  logic                 clk,
   input  logic                 nrst,
   mskaes_host_frontend_if.slave host,
   output logic                 busy,
   output logic                 err_timeout,
   output logic                 core_valid_in,
   input  logic                 core_ready,
   input  logic                 core_cipher_valid,
   output logic [BLK_W*d-1:0]   core_sh_plaintext,
   output logic [BLK_W*d-1:0]   core_sh_key,
   input  logic [BLK_W*d-1:0]   core_sh_ciphertext
);

   state_t               state;
   logic [BLK_W*d-1:0]   sh_pt_d, sh_key_d;
   logic [BLK_W*d-1:0]   sh_pt_q, sh_key_q;
   logic [BLK_W-1:0]     ct_q, ct_recomb;

   msk_share_split #(.d(d), .count(BLK_W)) u_split_pt (
      .x   (host.in_plaintext),
      .rnd (host.rnd_mask[BLK_W*(d-1)-1:0]),
      .sh  (sh_pt_d)
   );

   msk_share_split #(.d(d), .count(BLK_W)) u_split_key (
      .x   (host.in_key),
      .rnd (host.rnd_mask[2*BLK_W*(d-1)-1:BLK_W*(d-1)]),
      .sh  (sh_key_d)
   );

   for (genvar j = 0; j < BLK_W; j++) begin : g_recomb
      assign ct_recomb[j] = ^core_sh_ciphertext[d*j +: d];
   end

`ifdef MSKAES_WDOG_EN
   localparam int CNT_W = (TIMEOUT < 1024) ? 10 : $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] wdog_cnt;
   logic             err_q;
`endif

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state    <= ST_IDLE;
         // NOTE: share registers are wide but still reset, so no stale mask material survives a reset.
         sh_pt_q  <= '0;
         sh_key_q <= '0;
         ct_q     <= '0;
`ifdef MSKAES_WDOG_EN
         wdog_cnt <= '0;
         err_q    <= 1'b0;
`endif
      end else begin
`ifdef MSKAES_WDOG_EN
         err_q <= 1'b0;
`endif
         // NOTE: all state here uses <= so every branch sees the pre-edge values.
         unique case (state)
            ST_IDLE: if (host.in_valid) begin
               sh_pt_q  <= sh_pt_d;
               sh_key_q <= sh_key_d;
               state    <= ST_ISSUE;
            end
            ST_ISSUE: if (core_ready) begin
               sh_pt_q  <= '0;
               sh_key_q <= '0;
               state    <= ST_WAIT;
`ifdef MSKAES_WDOG_EN
               wdog_cnt <= '0;
`endif
            end
            ST_WAIT: begin
               if (core_cipher_valid) begin
                  ct_q  <= ct_recomb;
                  state <= ST_OUT;
               end
`ifdef MSKAES_WDOG_EN
               else if (wdog_cnt == CNT_W'(TIMEOUT - 1)) begin
                  err_q <= 1'b1;
                  state <= ST_IDLE;
               end else begin
                  wdog_cnt <= wdog_cnt + 1'b1;
               end
`endif
            end
            ST_OUT: if (host.out_ready) state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef MSKAES_WDOG_EN
   assign err_timeout = err_q;
`else
   assign err_timeout = 1'b0;
`endif

   assign host.in_ready       = (state == ST_IDLE);
   assign host.out_valid      = (state == ST_OUT);
   assign host.out_ciphertext = ct_q;
   assign busy                = (state != ST_IDLE);
   assign core_valid_in       = (state == ST_ISSUE);
   assign core_sh_plaintext   = sh_pt_q;
   assign core_sh_key         = sh_key_q;

endmodule

// File: tb/tb_mskaes_host_frontend.sv
// Scoreboard bench for mskaes_host_frontend with a behavioural stand-in for the masked core.
// Watchdog scenario is compiled in when MSKAES_WDOG_EN is defined.
module tb_mskaes_host_frontend;
   import mskaes_host_frontend_pkg::*;

   localparam int D  = 2;
   localparam int SW = BLK_W*D;
   localparam int HW = BLK_W*(D-1);
   localparam int RW = 2*HW;
`ifdef MSKAES_WDOG_EN
   localparam int TIMEOUT = 50;
`endif

   logic          clk = 1'b0;
   logic          nrst;
   logic          busy, err_timeout, core_valid_in, core_ready, core_cipher_valid;
   logic [SW-1:0] core_sh_plaintext, core_sh_key, core_sh_ciphertext;

   mskaes_host_frontend_if #(.d(D)) host_if ();

   mskaes_host_frontend #(
      .d(D)
`ifdef MSKAES_WDOG_EN
      , .TIMEOUT(TIMEOUT)
`endif
   ) dut (
      .clk                (clk),
      .nrst               (nrst),
      .host               (host_if),
      .busy               (busy),
      .err_timeout        (err_timeout),
      .core_valid_in      (core_valid_in),
      .core_ready         (core_ready),
      .core_cipher_valid  (core_cipher_valid),
      .core_sh_plaintext  (core_sh_plaintext),
      .core_sh_key        (core_sh_key),
      .core_sh_ciphertext (core_sh_ciphertext)
   );

   always #5 clk = ~clk;

   int               n_vec = 0;
   int               n_err = 0;
   logic [BLK_W-1:0] exp_q[$];
   logic [BLK_W-1:0] cur_pt, cur_key;
   logic [RW-1:0]    cur_rnd;
   int               fetches = 0;
   int               core_lat = 3;
   bit               core_stall = 1'b0;
   bit               core_mute = 1'b0;
   int               pend = 0;
   logic [BLK_W-1:0] pend_ct;
   logic [SW-1:0]    last_sh_pt;

   task automatic check(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   function automatic logic [SW-1:0] split_ref(input logic [BLK_W-1:0] x, input logic [HW-1:0] r);
      logic [SW-1:0] s;
      logic          b;
      s = '0;
      for (int j = 0; j < BLK_W; j++) begin
         b = x[j];
         for (int i = 1; i < D; i++) begin
            s[D*j+i] = r[(i-1)*BLK_W+j];
            b        = b ^ r[(i-1)*BLK_W+j];
         end
         s[D*j] = b;
      end
      return s;
   endfunction

   function automatic logic [BLK_W-1:0] recomb(input logic [SW-1:0] s);
      logic [BLK_W-1:0] x;
      x = '0;
      for (int j = 0; j < BLK_W; j++)
         for (int i = 0; i < D; i++) x[j] = x[j] ^ s[D*j+i];
      return x;
   endfunction

   function automatic logic [RW-1:0] rand_vec();
      logic [RW-1:0] v;
      for (int i = 0; i < RW/32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   function automatic logic [SW-1:0] reshare(input logic [BLK_W-1:0] ct);
      logic [HW-1:0] r;
      for (int i = 0; i < HW/32; i++) r[i*32 +: 32] = $urandom;
      return split_ref(ct, r);
   endfunction

   // Stand-in core: real AES answer for the FIPS vector, pt^key for anything else.
   function automatic logic [BLK_W-1:0] toy_core(input logic [BLK_W-1:0] pt, input logic [BLK_W-1:0] key);
      if (pt == FIPS_PT && key == FIPS_KEY) return FIPS_CT;
      return pt ^ key;
   endfunction

   initial begin
      core_ready         = 1'b1;
      core_cipher_valid  = 1'b0;
      core_sh_ciphertext = '0;
      forever begin
         @(negedge clk);
         core_cipher_valid = 1'b0;
         if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               core_cipher_valid  = 1'b1;
               core_sh_ciphertext = reshare(pend_ct);
            end
         end
         core_ready = !core_stall && (pend == 0);
         if (nrst === 1'b1 && core_valid_in === 1'b1 && core_ready) begin
            fetches++;
            check("fetch_pt_shares", core_sh_plaintext, split_ref(cur_pt, cur_rnd[HW-1:0]));
            check("fetch_key_shares", core_sh_key, split_ref(cur_key, cur_rnd[RW-1:HW]));
            last_sh_pt = core_sh_plaintext;
            if (!core_mute) begin
               pend    = core_lat;
               pend_ct = toy_core(recomb(core_sh_plaintext), recomb(core_sh_key));
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (nrst === 1'b1 && host_if.out_valid === 1'b1 && host_if.out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_output: got %h with nothing expected", host_if.out_ciphertext);
            end else begin
               check("ciphertext", SW'(host_if.out_ciphertext), SW'(exp_q.pop_front()));
            end
         end
`ifndef MSKAES_WDOG_EN
         if (err_timeout !== 1'b0) begin
            n_vec++;
            n_err++;
            $display("FAIL err_timeout_tied: got %b required 0", err_timeout);
         end
`endif
      end
   end

   task automatic send(input logic [BLK_W-1:0] pt, input logic [BLK_W-1:0] key,
                       input logic [RW-1:0] rnd, input logic [BLK_W-1:0] exp, input bit expect_out);
      int k;
      k = 0;
      while (host_if.in_ready !== 1'b1 && k < 200) begin
         @(negedge clk);
         k++;
      end
      if (k >= 200) check("send_in_ready_timeout", SW'(host_if.in_ready), SW'(1));
      cur_pt  = pt;
      cur_key = key;
      cur_rnd = rnd;
      host_if.in_plaintext = pt;
      host_if.in_key       = key;
      host_if.rnd_mask     = rnd;
      host_if.in_valid     = 1'b1;
      if (expect_out) exp_q.push_back(exp);
      @(negedge clk);
      host_if.in_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int k;
      k = 0;
      while (busy !== 1'b0 && k < 500) begin
         @(negedge clk);
         k++;
      end
      if (k >= 500) check({name, "_busy_timeout"}, SW'(busy), SW'(0));
   endtask

   logic [BLK_W-1:0] vec_pt[2]  = '{128'hffffffffffffffffffffffffffffffff, 128'h0123456789abcdef0123456789abcdef};
   logic [BLK_W-1:0] vec_key[2] = '{128'h00000000000000000000000000000000, 128'h00000000ffffffff00000000ffffffff};
   logic [BLK_W-1:0] vec_ct[2]  = '{128'hffffffffffffffffffffffffffffffff, 128'h01234567765432100123456776543210};

   initial begin
      logic [SW-1:0]    sh_zero_mask;
      logic [RW-1:0]    rnd;
      int               f0;
`ifdef MSKAES_WDOG_EN
      int               k;
`endif
      host_if.in_valid     = 1'b0;
      host_if.in_plaintext = '0;
      host_if.in_key       = '0;
      host_if.rnd_mask     = '0;
      host_if.out_ready    = 1'b1;
      nrst = 1'b0;
      #12;
      check("rst_in_ready", SW'(host_if.in_ready), SW'(1));
      check("rst_out_valid", SW'(host_if.out_valid), SW'(0));
      check("rst_core_valid_in", SW'(core_valid_in), SW'(0));
      check("rst_busy", SW'(busy), SW'(0));
      check("rst_err_timeout", SW'(err_timeout), SW'(0));
      check("rst_sh_pt", core_sh_plaintext, '0);
      check("rst_ciphertext", SW'(host_if.out_ciphertext), SW'(0));
      @(negedge clk);
      nrst = 1'b1;
      @(negedge clk);

      // FIPS vector, all-zero mask; shares must be wiped right after the fetch
      send(FIPS_PT, FIPS_KEY, '0, FIPS_CT, 1'b1);
      @(negedge clk);
      check("wait_sh_pt_zeroed", core_sh_plaintext, '0);
      check("wait_sh_key_zeroed", core_sh_key, '0);
      check("wait_core_valid_in", SW'(core_valid_in), SW'(0));
      check("wait_busy", SW'(busy), SW'(1));
      wait_idle("fips_zero");
      sh_zero_mask = last_sh_pt;

      // FIPS vector, random mask: same ciphertext, different shares
      send(FIPS_PT, FIPS_KEY, rand_vec(), FIPS_CT, 1'b1);
      wait_idle("fips_rand");
      check("shares_differ", SW'(last_sh_pt != sh_zero_mask), SW'(1));

      for (int v = 0; v < 2; v++) begin
         send(vec_pt[v], vec_key[v], rand_vec(), vec_ct[v], 1'b1);
         wait_idle("toy_vec");
      end

      // Output backpressure for 20 cycles, with a competing input offered
      host_if.out_ready = 1'b0;
      send(vec_pt[1], vec_key[1], rand_vec(), vec_ct[1], 1'b1);
      f0 = 0;
      while (host_if.out_valid !== 1'b1 && f0 < 100) begin
         @(negedge clk);
         f0++;
      end
      if (f0 >= 100) check("hold_out_valid_timeout", SW'(host_if.out_valid), SW'(1));
      f0 = fetches;
      host_if.in_plaintext = FIPS_PT;
      host_if.in_key       = FIPS_KEY;
      host_if.in_valid     = 1'b1;
      for (int c = 0; c < 20; c++) begin
         check("hold_ciphertext", SW'(host_if.out_ciphertext), SW'(vec_ct[1]));
         check("hold_out_valid", SW'(host_if.out_valid), SW'(1));
         check("hold_in_ready", SW'(host_if.in_ready), SW'(0));
         check("hold_busy", SW'(busy), SW'(1));
         @(negedge clk);
      end
      host_if.in_valid  = 1'b0;
      host_if.out_ready = 1'b1;
      @(negedge clk);
      check("release_busy", SW'(busy), SW'(0));
      check("release_in_ready", SW'(host_if.in_ready), SW'(1));
      check("release_out_valid", SW'(host_if.out_valid), SW'(0));
      check("hold_no_extra_fetch", SW'(fetches), SW'(f0));

      // Core busy for 5 cycles during ISSUE
      core_stall = 1'b1;
      rnd = rand_vec();
      send(vec_pt[0], vec_key[0], rnd, vec_ct[0], 1'b1);
      f0 = fetches;
      for (int c = 0; c < 5; c++) begin
         check("stall_core_valid_in", SW'(core_valid_in), SW'(1));
         check("stall_sh_pt_stable", core_sh_plaintext, split_ref(vec_pt[0], rnd[HW-1:0]));
         check("stall_sh_key_stable", core_sh_key, split_ref(vec_key[0], rnd[RW-1:HW]));
         @(negedge clk);
      end
      core_stall = 1'b0;
      wait_idle("stall");
      check("stall_single_fetch", SW'(fetches), SW'(f0 + 1));

      // Reset in the middle of WAIT; the late cipher_valid must be ignored
      core_lat = 8;
      send(FIPS_PT, FIPS_KEY, rand_vec(), FIPS_CT, 1'b1);
      repeat (3) @(negedge clk);
      #2;
      nrst = 1'b0;
      #1;
      check("midrst_out_valid", SW'(host_if.out_valid), SW'(0));
      check("midrst_in_ready", SW'(host_if.in_ready), SW'(1));
      check("midrst_busy", SW'(busy), SW'(0));
      exp_q.delete();
      @(negedge clk);
      nrst = 1'b1;
      repeat (8) @(negedge clk);
      check("stale_not_captured", SW'(busy), SW'(0));
      core_lat = 3;
      send(vec_pt[1], vec_key[1], rand_vec(), vec_ct[1], 1'b1);
      wait_idle("post_reset");

`ifdef MSKAES_WDOG_EN
      // Core never answers: watchdog fires TIMEOUT cycles into WAIT
      core_mute = 1'b1;
      send(FIPS_PT, FIPS_KEY, rand_vec(), FIPS_CT, 1'b0);
      @(negedge clk);
      k = 1;
      while (err_timeout !== 1'b1 && k < 4*TIMEOUT) begin
         @(negedge clk);
         k++;
      end
      check("wdog_cycles", SW'(k), SW'(TIMEOUT));
      check("wdog_busy", SW'(busy), SW'(0));
      check("wdog_out_valid", SW'(host_if.out_valid), SW'(0));
      @(negedge clk);
      check("wdog_pulse_width", SW'(err_timeout), SW'(0));
      core_mute = 1'b0;
      send(FIPS_PT, FIPS_KEY, rand_vec(), FIPS_CT, 1'b1);
      wait_idle("post_wdog");
`endif

      repeat (3) @(negedge clk);
      check("scoreboard_drained", SW'(exp_q.size()), SW'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1, "global timeout");
   end

endmodule
